// File: rtl/rr_mux_arb_pkg.sv
// Shared types for the round-robin 4:1 mux arbiter.
//   N_REQ        number of requesters sharing the mux
//   arb_state_t  ARB (no packet owner) / LOCK (owner holds the mux)
//   req_idx_t    requester index
package rr_mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker over four requesters.
//   valid  in   4  requesters presenting a beat
//   ptr    in   2  last granted index; scan starts at ptr+1
//   any    out  1  at least one requester is valid
//   idx    out  2  first valid index after ptr, wrapping (ptr itself last)
module rr_pick_4
    import rr_mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  req_idx_t         ptr,
    output logic             any,
    output req_idx_t         idx
);

    // Scan from the far end down so the nearest hit after ptr wins.
    // Offset N_REQ wraps to ptr itself, giving it the lowest priority.
    always_comb begin
        any = |valid;
        idx = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            if (valid[ptr + req_idx_t'(k)])
                idx = ptr + req_idx_t'(k);
        end
    end

endmodule

// File: rtl/rr_mux_4_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 data mux with packet locking
// and a registered output stage.
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_last[3:0]   per-requester handshake and end-of-packet
//   in_data0..3             per-requester data
//   in_ready[3:0]           one-hot accept (only the winner, only on load)
//   out_valid/out_ready     output register handshake
//   out_data/out_last       registered mux output
//   out_src                 registered index of the beat's source
module rr_mux_4_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [3:0]       in_last,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       out_src
);

    arb_state_t       state;
    req_idx_t         ptr;
    req_idx_t         owner;
    req_idx_t         pick_idx;
    req_idx_t         winner;
    logic             pick_any;
    logic             win_valid;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    // Output register is free, or its beat leaves this cycle.
    assign load = !out_valid | out_ready;

    rr_pick_4 u_pick (
        .valid (in_valid),
        .ptr   (ptr),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // While locked, only the owner is considered, even if it idles.
    assign winner    = (state == LOCK) ? owner : pick_idx;
    assign win_valid = (state == LOCK) ? in_valid[owner] : pick_any;

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign xfer = rst_n & load & win_valid;

    always_comb begin
        in_ready = '0;
        if (xfer)
            in_ready[winner] = 1'b1;
    end

    assign mux_data = (winner == 2'd0) ? in_data0 :
                      (winner == 2'd1) ? in_data1 :
                      (winner == 2'd2) ? in_data2 : in_data3;
    assign mux_last = in_last[winner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 2'd0;
            state     <= ARB;
            ptr       <= 2'd3;
            owner     <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= mux_last;
            out_src   <= winner;
            if (state == ARB) begin
                ptr <= winner;
                if (!mux_last) begin
                    state <= LOCK;
                    owner <= winner;
                end
            end else if (mux_last) begin
                state <= ARB;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_4_arbiter.sv
// Directed self-checking bench for rr_mux_4_arbiter.
module tb_rr_mux_4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic [1:0] out_src;

    int checks = 0;
    int errors = 0;

    rr_mux_4_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data0  = 4'h0;
        in_data1  = 4'h0;
        in_data2  = 4'h0;
        in_data3  = 4'h0;
        out_ready = 1'b1;

        // Reset state, with requests already pending
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_src",   out_src,   0);
        chk("rst_in_ready",  in_ready,  0);
        in_valid = 4'b0000;
        step();
        rst_n = 1'b1;

        // Single request
        in_valid = 4'b0001; in_last = 4'b0001; in_data0 = 4'hA;
        #1 chk("single_rdy", in_ready, 4'b0001);
        step();
        in_valid = 4'b0000;
        chk("single_valid", out_valid, 1);
        chk("single_data",  out_data,  4'hA);
        chk("single_src",   out_src,   0);
        chk("single_last",  out_last,  1);
        step();
        chk("drain_valid", out_valid, 0);

        // Rotation from reset priority
        do_reset();
        in_valid = 4'b1111; in_last = 4'b1111;
        in_data0 = 4'd1; in_data1 = 4'd2; in_data2 = 4'd3; in_data3 = 4'd4;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rot_rdy", in_ready, 4'b0001 << (i % 4));
            step();
            chk("rot_src",  out_src,  i % 4);
            chk("rot_data", out_data, (i % 4) + 1);
        end

        // Packet lock: requester 1 sends 3 beats while others are valid
        in_data1 = 4'd5; in_last = 4'b1101;
        #1 chk("lock_b1_rdy", in_ready, 4'b0010);
        step();
        chk("lock_b1_data", out_data, 5);
        chk("lock_b1_last", out_last, 0);
        in_data1 = 4'd6; in_valid = 4'b1101;
        #1 chk("lock_gap_rdy", in_ready, 4'b0000);
        step();
        chk("lock_gap_valid", out_valid, 0);
        in_valid = 4'b1111;
        #1 chk("lock_b2_rdy", in_ready, 4'b0010);
        step();
        chk("lock_b2_data", out_data, 6);
        in_data1 = 4'd7; in_last = 4'b1111;
        #1 chk("lock_b3_rdy", in_ready, 4'b0010);
        step();
        chk("lock_b3_data", out_data, 7);
        chk("lock_b3_last", out_last, 1);
        #1 chk("post_lock_rdy", in_ready, 4'b0100);
        step();
        chk("post_lock_src", out_src, 2);

        // Backpressure with all requesters valid
        in_data1 = 4'd2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_rdy", in_ready, 4'b0000);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data",  out_data,  3);
            chk("bp_src",   out_src,   2);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            w = (3 + j) % 4;
            #1 chk("rel_rdy", in_ready, 4'b0001 << w);
            step();
            chk("rel_src",  out_src,  w);
            chk("rel_data", out_data, w + 1);
        end

        // Back-to-back single-beat stream from requester 2
        in_valid = 4'b0100; in_last = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            in_data2 = 4'(i);
            #1 chk("b2b_rdy", in_ready, 4'b0100);
            step();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data",  out_data,  i);
        end

        // Reset in the middle of a packet from requester 3
        do_reset();
        in_valid = 4'b1000; in_last = 4'b0000; in_data3 = 4'd9;
        #1 chk("mid_b1_rdy", in_ready, 4'b1000);
        step();
        in_data3 = 4'd10;
        step();
        chk("mid_b2_valid", out_valid, 1);
        chk("mid_b2_data",  out_data,  10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data",  out_data,  0);
        chk("mid_rst_rdy",   in_ready,  0);
        step();
        rst_n = 1'b1;
        in_valid = 4'b1001; in_last = 4'b1001; in_data0 = 4'hC;
        #1 chk("post_rst_rdy", in_ready, 4'b0001);
        step();
        chk("post_rst_src",  out_src,  0);
        chk("post_rst_data", out_data, 4'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_4_arbiter.md
# rr_mux_4_arbiter

Round-robin arbiter sharing one 4:1 data multiplexer among four valid/ready requesters, with packet locking and a registered output stage. Each cycle it picks one requester, steers that requester's data through the mux select, and holds the result in an output register until the downstream consumer takes it. It sits between the four source ports and a single shared downstream sink.

## Interface
- `WIDTH`, default 4: data width of every input and of the output.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous reset, active-low; one clock domain only.
- `in_valid`  input  4  bit i: requester i presents a beat.
- `in_last`  input  4  bit i: the beat on requester i ends its packet.
- `in_data0` .. `in_data3`  input  WIDTH each  requester data.
- `in_ready`  output  4  bit i: the beat from requester i is accepted this cycle. At most one bit is set.
- `out_valid`  output  1  the output register holds a beat.
- `out_ready`  input  1  the sink accepts the beat this cycle.
- `out_data`  output  WIDTH  registered mux output.
- `out_last`  output  1  registered last flag.
- `out_src`  output  2  registered select, the index of the source of `out_data`.

## Operation
- A transfer on side X happens when `X_valid & X_ready` is true at the clock edge.
- `load = !out_valid | out_ready`. This is the output register's free or draining condition.
- FSM states:
  - ARB: no packet owner.
  - LOCK: the owner is the register `owner[1:0]`.
- **Candidate selection**
  - In ARB, the candidates are all requesters with `in_valid`.
  - In ARB, the winner is the first candidate scanning `ptr+1, ptr+2, ptr+3, ptr` (mod 4).
  - In LOCK, the only candidate is `owner`. `in_valid` of any other requester is ignored.
- `in_ready[w] = load & in_valid[w]` for the winner w. All other bits are 0. `in_ready` may depend combinationally on `in_valid`; sources must not do the reverse.
- **On an input transfer from w**
  - `out_data <= in_data_w`, `out_last <= in_last[w]`, `out_src <= w`, `out_valid <= 1`.
  - In ARB: `ptr <= w`. If `in_last[w]=0`, go to LOCK with `owner <= w`.
  - In LOCK: if `in_last[w]=1`, go to ARB.
- **Output only:** an output transfer with no input transfer sets `out_valid <= 0`.
- **Simultaneous events:** output and input transfer in the same cycle is a back-to-back refill with no bubble.
- **Stall:** while `out_valid & !out_ready`, the output register, FSM, `ptr` and `owner` hold, and all of `in_ready` is 0.
- **Starvation bound:** a requester that holds `in_valid` continuously is granted within 3 foreign packets.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`.
  - FSM=ARB, `ptr=3` (requester 0 has first priority), `owner=0`.
- `in_ready` is 0 throughout reset.
- Latency: an input beat accepted at edge k is visible on the outputs after edge k. That is 1 cycle.
- Throughput: 1 beat per cycle when `out_ready` is held at 1.
- **Reset mid-packet:** asserting `rst_n=0` immediately clears the output register and returns the FSM to ARB. The partial packet is dropped and no completion is owed.
- **Single-beat packets** (`in_last=1` on the first beat) never enter LOCK.
- **Owner drops `in_valid` in LOCK:** the grant stays locked. No other requester is served until the owner's last beat.
- All state updates are on the rising `clk` edge. The only asynchronous path is reset.

## Structure
- Package `rr_mux_arb_pkg`:
  - `N_REQ = 4`.
  - `typedef enum logic {ARB, LOCK} arb_state_t`.
  - `typedef logic [1:0] req_idx_t`.
- Sub-module `rr_pick_4`. It is combinational and takes `valid[3:0]` and `ptr`. It returns `any` and `idx`: the first valid after `ptr`, wrapping.
- Top level contents:
  - the FSM
  - `ptr` and `owner` registers
  - a 4:1 data/last mux using `?:` on the winner index
  - the output register

## Test plan
- **Reset, then single request:** `in_valid=0001`, `in_data0=4'hA`, `in_last=0001`, `out_ready=1`. Require `in_ready=0001` in the same cycle. On the next cycle require `out_valid=1`, `out_data=A`, `out_src=0`.
- **Rotation:** all four valid with single-beat packets and `out_ready=1`. Require grants in the order 0,1,2,3,0 on consecutive cycles, with `out_src` following one cycle later.
- **Packet lock:** requester 1 sends 3 beats (last on the third) while requesters 0, 2 and 3 are valid. Require `in_ready` to be 0010 for 3 accepted beats, then a grant to 2.
- **Backpressure:** `out_ready=0` for 4 cycles with all requesters valid. Require `out_data` and `out_src` stable and `in_ready=0000`. On release, require one beat per cycle with no loss or duplication.
- **Back-to-back:** `out_ready=1` and continuous `in_valid=0100`, data 0..7. Require 8 outputs on 8 consecutive cycles with data 0..7.
- **Reset mid-packet:** assert `rst_n=0` after beat 2 of a 4-beat packet from requester 3. Require `out_valid` to drop immediately. After reset, require requester 0 to win over 3 when both are valid.
